// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges IF/ID/MEM stall requests and EX redirects; defers redirects while IF fetch is outstanding.
// Ports: clk_in, rst_in (sync, active high), rdy_in, stallreq_from_{if,id,mem},
//   branch_taken_in, branch_target_in -> stall_out[pc,if,id,ex,mem,wb], flush_out,
//   pc_redirect_out, pc_target_out, if_timeout_out (sticky).
// Optional macro PIPE_CTRL_PERF_EN adds perf_stall_cycles_out / perf_flush_count_out.
module pipe_ctrl #(
  parameter int IF_WAIT_MAX = 64,
  parameter int STALL_W     = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               stallreq_from_if,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_mem,
  input  logic               branch_taken_in,
  input  logic [31:0]        branch_target_in,
  output logic [STALL_W-1:0] stall_out,
  output logic               flush_out,
  output logic               pc_redirect_out,
  output logic [31:0]        pc_target_out,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]        perf_stall_cycles_out,
  output logic [31:0]        perf_flush_count_out,
`endif
  output logic               if_timeout_out
);

  typedef enum logic {
    RUN,
    WAIT_IF
  } state_t;

  localparam int CW = $clog2(IF_WAIT_MAX + 1);
  localparam logic [CW-1:0] CMAX   = CW'(IF_WAIT_MAX);
  localparam logic [CW-1:0] CMAXM1 = CW'(IF_WAIT_MAX - 1);

  localparam logic [STALL_W-1:0] S_NONE = STALL_W'(6'b000000);
  localparam logic [STALL_W-1:0] S_IF   = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] S_ID   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] S_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] S_ALL  = STALL_W'(6'b111111);

  state_t        r_state;
  state_t        w_nstate;
  logic [31:0]   r_target;
  logic [31:0]   w_ntarget;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic          r_timeout;
  logic          w_ntimeout;

  always_comb begin
    w_nstate        = r_state;
    w_ntarget       = r_target;
    w_ncnt          = r_cnt;
    w_ntimeout      = r_timeout;
    stall_out       = S_NONE;
    flush_out       = 1'b0;
    pc_redirect_out = 1'b0;
    pc_target_out   = (r_state == WAIT_IF) ? r_target : 32'h0;
    if (rst_in) begin
      pc_target_out = 32'h0;
    end else if (!rdy_in) begin
      stall_out = S_ALL;
    end else if (stallreq_from_mem) begin
      // EX is held, so a branch there is re-presented once MEM drains
      stall_out = S_MEM;
    end else if (r_state == RUN && branch_taken_in) begin
      flush_out = 1'b1;
      if (!stallreq_from_if) begin
        // ID stall masked: ID holds a wrong-path instruction
        pc_redirect_out = 1'b1;
        pc_target_out   = branch_target_in;
      end else begin
        stall_out = S_IF;
        w_ntarget = branch_target_in;
        w_ncnt    = '0;
        w_nstate  = WAIT_IF;
      end
    end else if (r_state == WAIT_IF) begin
      if (stallreq_from_if) begin
        stall_out = S_ID;
        if (r_cnt != CMAX) w_ncnt = r_cnt + 1'b1;
        if (r_cnt == CMAXM1) w_ntimeout = 1'b1;
      end else begin
        // fire deferred redirect; flush drops the stale fetched word
        pc_redirect_out = 1'b1;
        pc_target_out   = r_target;
        flush_out       = 1'b1;
        w_nstate        = RUN;
      end
    end else if (stallreq_from_id) begin
      stall_out = S_ID;
    end else if (stallreq_from_if) begin
      stall_out = S_IF;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= RUN;
      r_target  <= 32'h0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (rdy_in) begin
      r_state   <= w_nstate;
      r_target  <= w_ntarget;
      r_cnt     <= w_ncnt;
      r_timeout <= w_ntimeout;
    end
  end

  assign if_timeout_out = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_perf_stall <= 32'h0;
      r_perf_flush <= 32'h0;
    end else begin
      if (rdy_in && stall_out != S_NONE) r_perf_stall <= r_perf_stall + 32'h1;
      if (flush_out) r_perf_flush <= r_perf_flush + 32'h1;
    end
  end

  assign perf_stall_cycles_out = r_perf_stall;
  assign perf_flush_count_out  = r_perf_flush;
`endif

endmodule
